uninasoc_irq_gateway: RTL
=========================

Name: uninasoc_irq_gateway

Overview:
- Parametrised platform-interrupt gateway and arbiter. It generalises the fixed 32-line static PLIC source map into a configurable source count.
- Adds per-source level/edge mode, enable, priority and threshold, plus a claim/complete handshake.
- Sits between PBUS/peripheral interrupt lines and the core external-interrupt input (CORE_EXT_INTERRUPT, mcause 11).
- Drives one hart target. Register-map glue is in a separate AXI-Lite wrapper.

Parameters:
- NUM_SOURCES, 32: interrupt lines including reserved line 0. Legal range 2..64.
- PRIO_WIDTH, 3: priority bits per source. Priority 0 means never interrupt.
- ID_WIDTH, $clog2(NUM_SOURCES): width of source IDs.

Ports:
- clock_i  in  1  system clock
- reset_ni  in  1  asynchronous active-low reset
- irq_src_i  in  NUM_SOURCES  raw interrupt lines, asynchronous to clock_i. Bit 0 is ignored.
- edge_mode_i  in  NUM_SOURCES  1 = rising-edge triggered, 0 = level (high) triggered
- enable_i  in  NUM_SOURCES  per-source enable
- prio_i  in  NUM_SOURCES*PRIO_WIDTH  packed priorities; source k occupies [k*PRIO_WIDTH +: PRIO_WIDTH]
- threshold_i  in  PRIO_WIDTH  target priority threshold
- claim_i  in  1  single-cycle claim strobe
- claim_valid_o  out  1  pulse, one cycle after claim_i
- claim_id_o  out  ID_WIDTH  claimed ID; 0 = nothing claimable
- complete_i  in  1  single-cycle completion strobe
- complete_id_i  in  ID_WIDTH  ID being completed
- pending_o  out  NUM_SOURCES  per-source pending state, for debug/readback
- irq_o  out  1  registered external interrupt request to the core

Behaviour:
- Reset: all synchroniser, edge and state flops go to 0/IDLE. claim_valid_o=0, claim_id_o=0, pending_o=0, irq_o=0. Reset takes effect immediately, including mid-service; in-service sources return to IDLE.
- Input path: 2-flop synchroniser per source giving s2. A further flop s3 is used for edge detection; rise = s2 & ~s3.
- Trigger: trig_k = edge_mode_k ? rise_k : s2_k. The trigger is evaluated regardless of enable_i; enable only masks arbitration.
- Per-source FSM (k>=1) with states IDLE, PENDING, SERVICE, plus an edge_seen_k flag:
  - IDLE -> PENDING on trig_k.
  - PENDING -> SERVICE when claimed. A level pending stays latched even if the line drops before the claim.
  - SERVICE -> IDLE on complete_i with complete_id_i==k and edge_seen_k=0.
  - SERVICE -> PENDING on that same completion if edge_seen_k=1 (edge_seen_k then clears), or if the source is level-mode with s2_k high.
  - edge_seen_k sets on rise_k while the source is PENDING or SERVICE, and holds a single extra edge only; further edges are lost.
- Source 0: hardwired IDLE. It is never pending and never claimable.
- pending_o[k] = (state_k==PENDING).
- Arbitration (combinational, from current state):
  - Candidates are PENDING & enable_i & prio>threshold_i.
  - Highest prio wins; ties go to the lowest ID.
  - best_id = 0 if there is no candidate.
- irq_o is registered: irq_o <= (best_id != 0). It has 1 cycle latency from the state change.
- Latency: a level input stable high before edge 1 is in s2 at edge 2, PENDING at edge 3, and irq_o=1 at edge 4.
- Claim: claim_i at cycle N samples best_id of cycle N.
  - At edge N+1: claim_id_o <= best_id, claim_valid_o <= 1 (for one cycle), and source best_id goes to SERVICE.
  - Back-to-back claims are legal; each sees the updated state.
  - A claim with no candidate returns 0 and changes no state.
  - claim_id_o holds its value until the next claim.
- Complete:
  - complete_id_i == 0, out of range, or not in SERVICE: ignored.
  - Claim and complete in the same cycle are both applied. They cannot target the same source, since a claim only takes PENDING sources.
- Mode or enable changes take effect on the next evaluation. Disabling a PENDING source keeps it pending but masked.
- Trigger during PENDING: absorbed, except that an edge sets edge_seen_k.

Test Plan:
- Level source 4 (prio 3, threshold 0) held high from cycle 0 -> irq_o=1 at edge 4. claim_i -> claim_id_o=4 with claim_valid_o pulse, irq_o=0 one cycle later. complete(4) with line still high -> pending again, irq_o=1 two cycles later.
- Sources 2 and 3 both pending at prio 5, source 1 at prio 2 -> claims return 2, then 3, then 1, then 0. irq_o falls after the third claim.
- Edge source 2: one pulse, claim, then a second rising edge during SERVICE, then complete(2) -> PENDING again, next claim returns 2. A third edge during SERVICE is not recorded twice: after the next complete, only one extra claim is possible.
- Threshold: source 5 at prio 2 with threshold_i=2 -> irq_o=0 and claim returns 0. Setting threshold_i=1 -> irq_o=1 one cycle later.
- Disable pending source 6 -> irq_o=0 and pending_o[6]=1. Re-enable -> irq_o=1. complete(7) while 7 is IDLE -> no state change. irq_src_i[0] high -> never pending.
- Assert reset_ni=0 with source 3 in SERVICE and source 4 pending -> all outputs 0 immediately. After release, level source 4 (still high) pends again with irq_o=1 at edge 4.

Source files
------------

// File: rtl/uninasoc_irq_gateway.sv
// Platform interrupt gateway for a single hart. It synchronises the interrupt lines,
// tracks a pending/in-service state per source, and arbitrates by priority with a claim/complete handshake.
module uninasoc_irq_gateway #(
    parameter int NUM_SOURCES = 32,
    parameter int PRIO_WIDTH  = 3,
    parameter int ID_WIDTH    = $clog2(NUM_SOURCES)
) (
    input  logic                             clock_i,
    input  logic                             reset_ni,
    input  logic [NUM_SOURCES-1:0]           irq_src_i,
    input  logic [NUM_SOURCES-1:0]           edge_mode_i,
    input  logic [NUM_SOURCES-1:0]           enable_i,
    input  logic [NUM_SOURCES*PRIO_WIDTH-1:0] prio_i,
    input  logic [PRIO_WIDTH-1:0]            threshold_i,
    input  logic                             claim_i,
    output logic                             claim_valid_o,
    output logic [ID_WIDTH-1:0]              claim_id_o,
    input  logic                             complete_i,
    input  logic [ID_WIDTH-1:0]              complete_id_i,
    output logic [NUM_SOURCES-1:0]           pending_o,
    output logic                             irq_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        SERVICE = 2'd2
    } src_state_e;

    src_state_e state_q [NUM_SOURCES];
    src_state_e state_d [NUM_SOURCES];

    logic [NUM_SOURCES-1:0] sync1_q, sync2_q, sync3_q;
    logic [NUM_SOURCES-1:0] edge_seen_q, edge_seen_d;
    logic [NUM_SOURCES-1:0] rise, trig;
    logic [ID_WIDTH-1:0]    best_id;
    logic [PRIO_WIDTH-1:0]  best_prio;
    logic                   found;
    logic                   claim_take;

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            sync1_q <= '0;
            sync2_q <= '0;
            sync3_q <= '0;
        end else begin
            sync1_q <= irq_src_i;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    assign rise = sync2_q & ~sync3_q;
    assign trig = (edge_mode_i & rise) | (~edge_mode_i & sync2_q);

    // Ascending scan with a strict compare, so equal priorities resolve to the lowest ID.
    always_comb begin
        best_id   = '0;
        best_prio = '0;
        found     = 1'b0;
        for (int k = 0; k < NUM_SOURCES; k++) begin
            if (state_q[k] == PENDING && enable_i[k] &&
                prio_i[k*PRIO_WIDTH +: PRIO_WIDTH] > threshold_i) begin
                if (!found || prio_i[k*PRIO_WIDTH +: PRIO_WIDTH] > best_prio) begin
                    found     = 1'b1;
                    best_prio = prio_i[k*PRIO_WIDTH +: PRIO_WIDTH];
                    best_id   = ID_WIDTH'(k);
                end
            end
        end
    end

    assign claim_take = claim_i && found;

    // An edge arriving in the same cycle as the completion counts as the one remembered edge.
    always_comb begin
        for (int k = 0; k < NUM_SOURCES; k++) begin
            state_d[k]     = state_q[k];
            edge_seen_d[k] = edge_seen_q[k];
            pending_o[k]   = (state_q[k] == PENDING);
            case (state_q[k])
                IDLE: begin
                    if (trig[k]) state_d[k] = PENDING;
                end
                PENDING: begin
                    if (rise[k]) edge_seen_d[k] = 1'b1;
                    if (claim_take && best_id == ID_WIDTH'(k)) state_d[k] = SERVICE;
                end
                SERVICE: begin
                    if (complete_i && complete_id_i == ID_WIDTH'(k)) begin
                        edge_seen_d[k] = 1'b0;
                        if (edge_seen_q[k] || rise[k] || (!edge_mode_i[k] && sync2_q[k]))
                            state_d[k] = PENDING;
                        else
                            state_d[k] = IDLE;
                    end else if (rise[k]) begin
                        edge_seen_d[k] = 1'b1;
                    end
                end
                default: begin
                    state_d[k]     = IDLE;
                    edge_seen_d[k] = 1'b0;
                end
            endcase
        end
        state_d[0]     = IDLE;
        edge_seen_d[0] = 1'b0;
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            for (int k = 0; k < NUM_SOURCES; k++) state_q[k] <= IDLE;
            edge_seen_q   <= '0;
            irq_o         <= 1'b0;
            claim_valid_o <= 1'b0;
            claim_id_o    <= '0;
        end else begin
            for (int k = 0; k < NUM_SOURCES; k++) state_q[k] <= state_d[k];
            edge_seen_q   <= edge_seen_d;
            irq_o         <= found;
            claim_valid_o <= claim_i;
            if (claim_i) claim_id_o <= best_id;
        end
    end

endmodule
